// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader_pkg
//  Purpose  : Shared CPU package holding the program loader state encoding,
//             the header length and the memory address widths used to size
//             the instruction and data memories.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package program_loader_pkg;

  // Word address widths of the instruction and data memories
  localparam int IMEM_ADDR_W = 9;
  localparam int DMEM_ADDR_W = 10;

  // Number of header words preceding the payload (N_i, then N_d)
  localparam int HDR_WORDS = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_I  = 3'd1,
    ST_HDR_D  = 3'd2,
    ST_LOAD_I = 3'd3,
    ST_LOAD_D = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

endpackage : program_loader_pkg
`default_nettype wire

// File: rtl/loader_wr_port.sv
`default_nettype none
// ============================================================================
//  Module   : loader_wr_port
//  Purpose  : Registered memory write stage. A request presented in one cycle
//             appears as a one-cycle strobe with byte address and data in the
//             next cycle. Address and data hold when no request is made.
//  Ports    : clk, arst       - clock, asynchronous active-high reset
//             req             - write request this cycle
//             word_idx[31:0]  - word index of the request
//             req_data[31:0]  - word to write
//             addr[31:0]      - registered byte address (word_idx << 2)
//             wen             - registered write strobe
//             wdata[31:0]     - registered write word
//  Revision : 1.0  initial release
// ============================================================================
module loader_wr_port (
  input  logic        clk,
  input  logic        arst,
  input  logic        req,
  input  logic [31:0] word_idx,
  input  logic [31:0] req_data,
  output logic [31:0] addr,
  output logic        wen,
  output logic [31:0] wdata
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      addr  <= 32'd0;
      wen   <= 1'b0;
      wdata <= 32'd0;
    end else begin
      wen <= req;
      if (req) begin
        addr  <= {word_idx[29:0], 2'b00};
        wdata <= req_data;
      end
    end
  end

endmodule : loader_wr_port
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Streams a program image (header N_i, N_d, then N_i instruction
//             words and N_d data words) into instruction and data memories,
//             then enables the CPU. Oversized headers park the loader in ERR.
//  Ports    : clk, arst              - clock, asynchronous active-high reset
//             start, stop            - control pulses
//             s_valid/s_data/s_ready - upstream word stream
//             addr_ext/wen_ext/wdata_ext       - instruction memory write
//             addr_ext_2/wen_ext_2/wdata_ext_2 - data memory write
//             cpu_enable             - high while in RUN
//             busy                   - high while receiving header/payload
//             error                  - high in ERR
//  Revision : 1.0  initial release
// ============================================================================
module program_loader
  import program_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 2 ** IMEM_ADDR_W,
  parameter int DMEM_DEPTH = 2 ** DMEM_ADDR_W
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic        stop,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic [31:0] wdata_ext,
  output logic [31:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic [31:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        error
);

  loader_state_t state, state_nxt;

  logic [31:0] n_i;
  logic [31:0] n_d;
  logic [31:0] cnt_i;
  logic [31:0] cnt_d;

  logic xfer;
  logic req_i;
  logic req_d;
  logic last_i;
  logic last_d;

  // A stop pulse wins over a simultaneous word: the word is discarded.
  assign xfer   = s_valid && s_ready && !stop;
  assign req_i  = xfer && (state == ST_LOAD_I);
  assign req_d  = xfer && (state == ST_LOAD_D);
  assign last_i = (cnt_i == n_i - 32'd1);
  assign last_d = (cnt_d == n_d - 32'd1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_HDR_I;
      end
      ST_HDR_I: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (xfer) begin
          state_nxt = (s_data > 32'(IMEM_DEPTH)) ? ST_ERR : ST_HDR_D;
        end
      end
      ST_HDR_D: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (xfer) begin
          if (s_data > 32'(DMEM_DEPTH)) state_nxt = ST_ERR;
          else if (n_i != 32'd0)        state_nxt = ST_LOAD_I;
          else if (s_data != 32'd0)     state_nxt = ST_LOAD_D;
          else                          state_nxt = ST_RUN;
        end
      end
      ST_LOAD_I: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (xfer && last_i) begin
          state_nxt = (n_d != 32'd0) ? ST_LOAD_D : ST_RUN;
        end
      end
      ST_LOAD_D: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (xfer && last_d) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        if (stop) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Header latches and word counters; a fresh start clears everything so a
  // previous aborted load leaves no trace.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      n_i   <= 32'd0;
      n_d   <= 32'd0;
      cnt_i <= 32'd0;
      cnt_d <= 32'd0;
    end else begin
      if (state == ST_IDLE && start) begin
        n_i   <= 32'd0;
        n_d   <= 32'd0;
        cnt_i <= 32'd0;
        cnt_d <= 32'd0;
      end
      if (xfer && state == ST_HDR_I) n_i <= s_data;
      if (xfer && state == ST_HDR_D) n_d <= s_data;
      if (req_i) cnt_i <= cnt_i + 32'd1;
      if (req_d) cnt_d <= cnt_d + 32'd1;
    end
  end

  assign s_ready    = (state == ST_HDR_I) || (state == ST_HDR_D) ||
                      (state == ST_LOAD_I) || (state == ST_LOAD_D);
  assign busy       = s_ready;
  assign cpu_enable = (state == ST_RUN);
  assign error      = (state == ST_ERR);

  loader_wr_port u_imem_port (
    .clk      (clk),
    .arst     (arst),
    .req      (req_i),
    .word_idx (cnt_i),
    .req_data (s_data),
    .addr     (addr_ext),
    .wen      (wen_ext),
    .wdata    (wdata_ext)
  );

  loader_wr_port u_dmem_port (
    .clk      (clk),
    .arst     (arst),
    .req      (req_d),
    .word_idx (cnt_d),
    .req_data (s_data),
    .addr     (addr_ext_2),
    .wen      (wen_ext_2),
    .wdata    (wdata_ext_2)
  );

endmodule : program_loader
`default_nettype wire

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 512, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter DMEM_DEPTH, default 1024, data-memory capacity in 32-bit words.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port arst  input  1  reset; one clock, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load from IDLE.
REQ-006 SHALL have port stop  input  1  one-cycle pulse that halts the CPU and returns to IDLE.
REQ-007 SHALL have port s_valid  input  1  upstream word valid.
REQ-008 SHALL have port s_data  input  32  upstream word.
REQ-009 SHALL have port s_ready  output  1  loader accepts s_data this cycle.
REQ-010 SHALL have port addr_ext  output  32  instruction-memory byte address.
REQ-011 SHALL have port wen_ext  output  1  instruction-memory write strobe.
REQ-012 SHALL have port wdata_ext  output  32  instruction-memory write word.
REQ-013 SHALL have port addr_ext_2  output  32  data-memory byte address.
REQ-014 SHALL have port wen_ext_2  output  1  data-memory write strobe.
REQ-015 SHALL have port wdata_ext_2  output  32  data-memory write word.
REQ-016 SHALL have port cpu_enable  output  1  drives CPU enable.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE, RUN, ERR.
REQ-018 SHALL have port error  output  1  high in ERR.

Function
REQ-019 SHALL implement states IDLE, HDR_I, HDR_D, LOAD_I, LOAD_D, RUN, ERR.
REQ-020 SHALL define a transfer as s_valid && s_ready at a rising edge; s_ready high only in HDR_I, HDR_D, LOAD_I, LOAD_D.
REQ-021 IDLE: start -> HDR_I; all other inputs ignored.
REQ-022 HDR_I: transfer latches N_i = s_data; N_i > IMEM_DEPTH -> ERR, else -> HDR_D.
REQ-023 HDR_D: transfer latches N_d = s_data; N_d > DMEM_DEPTH -> ERR; else N_i != 0 -> LOAD_I, N_i == 0 && N_d != 0 -> LOAD_D, both zero -> RUN.
REQ-024 LOAD_I: k-th transfer (k from 0) SHALL produce, registered one cycle later, wen_ext=1, addr_ext=4*k, wdata_ext=s_data for exactly one cycle per transfer.
REQ-025 LOAD_I: after transfer N_i-1 -> LOAD_D if N_d != 0, else RUN.
REQ-026 LOAD_D: same rule as REQ-024 on the _2 ports with its own counter from 0; after transfer N_d-1 -> RUN.
REQ-027 Word counters SHALL be 32-bit wide; byte address = counter shifted left 2; no wrap is possible because of REQ-022/023.
REQ-028 Back-to-back transfers SHALL sustain one word per cycle; s_valid low stalls with no write strobe.
REQ-029 cpu_enable SHALL be 1 exactly while in RUN; entering RUN occurs the edge after the final transfer, so the final memory write and cpu_enable rise in the same cycle.
REQ-030 RUN: stop -> IDLE (cpu_enable falls next cycle); start ignored.
REQ-031 ERR: stop -> IDLE; otherwise held; no write strobes, cpu_enable 0.
REQ-032 stop in HDR_*/LOAD_* SHALL abort to IDLE; a transfer in the same cycle SHALL be discarded (no strobe).
REQ-033 wen_ext and wen_ext_2 SHALL never be high in the same cycle.
REQ-034 Address/data outputs SHALL hold their last value when strobes are low.

Reset
REQ-035 arst high SHALL immediately force IDLE, counters 0, N_i/N_d 0, and all outputs 0, including mid-load; no partial strobe after reset release.
REQ-036 After arst release, first action SHALL require a new start pulse.

Structure
REQ-037 State enumeration and the header-word count (2) SHALL live in the shared CPU package; IMEM_DEPTH/DMEM_DEPTH defaults SHALL match the memory ADDR_W settings (2**9, 2**10).
REQ-038 One sub-module SHALL be used: loader_wr_port, a registered address/data/strobe stage instantiated twice (instruction and data memory).

Verification
REQ-039 Header 3,2 then words A0..A2,D0,D1 back-to-back -> imem writes at 0,4,8; dmem writes at 0,4; cpu_enable high in the cycle of the D1 write.
REQ-040 Header 0,0 -> RUN two edges after start+headers; no write strobe observed.
REQ-041 Header 513,x -> ERR, error=1, s_ready=0; stop -> IDLE, error=0.
REQ-042 Header 4,0 with s_valid toggling every other cycle -> exactly 4 imem strobes at 0,4,8,12, none during gaps.
REQ-043 arst asserted after 2nd imem word of header 5,1 -> outputs 0 asynchronously; after release, s_valid ignored until start.
REQ-044 In RUN, stop pulse -> cpu_enable 0 next cycle; start in same cycle as stop -> stays IDLE.
